// File: rtl/fsm_unit_scheduler_pkg.sv
// Shared types and default widths for the round-robin unit scheduler.
// Holds the 2-bit state encoding and default parameter values.
package fsm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ID_W    = 3;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/fsm_unit_scheduler_if.sv
// Bundle of requester, unit and response signals around the scheduler.
// master: scheduler side; slave: requesters + unit + response consumer.
interface fsm_unit_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      unit_start;
    logic [DATA_W-1:0]         unit_in;
    logic                      unit_done;
    logic [DATA_W-1:0]         unit_out;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_err;

    modport master (
        input  req, req_data, unit_done, unit_out, resp_ready,
        output gnt, unit_start, unit_in,
        output resp_valid, resp_id, resp_data, resp_err
    );

    modport slave (
        output req, req_data, unit_done, unit_out, resp_ready,
        input  gnt, unit_start, unit_in,
        input  resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/fsm_unit_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
// Ports: req, ptr in; win (winner index) and any (req != 0) out.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    win,
    output logic               any
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] rot;
    logic [ID_W-1:0]      off;
    logic [ID_W:0]        sum;

    // Rotating a doubled copy puts requester (ptr+k) mod NUM_REQ at bit k.
    assign dbl = {req, req};
    assign rot = dbl >> ptr;
    assign any = |req;

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = ID_W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
        end
        win = sum[ID_W-1:0];
    end
endmodule

// File: rtl/fsm_unit_scheduler.sv
// Round-robin scheduler sharing one start/done compute unit among NUM_REQ requesters.
// Ports: clk, reset (async, active-low), bus (master modport: req/gnt, unit, resp).
// Optional macro SCHED_TIMEOUT_EN aborts a job after TIMEOUT_CYCLES WAIT cycles.
module fsm_unit_scheduler
    import fsm_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ID_W           = DEF_ID_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 reset,
    fsm_unit_scheduler_if.master bus
);
    if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** ID_W) < NUM_REQ
        || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fsm_unit_scheduler: bad parameter set");
    end

    sched_state_t       state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               unit_start_q, unit_start_d;
    logic [DATA_W-1:0]  unit_in_q, unit_in_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;

    logic [ID_W-1:0]    win;
    logic               any;
    logic [DATA_W-1:0]  win_data;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    // cnt_q counts completed WAIT cycles, so this cycle is the last allowed one.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (bus.req),
        .ptr (rr_ptr_q),
        .win (win),
        .any (any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) win_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_id_d     = cur_id_q;
        gnt_d        = '0;
        unit_start_d = 1'b0;
        unit_in_d    = unit_in_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
`ifdef SCHED_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d     = NUM_REQ'(1) << win;
                    unit_in_d = win_data;
                    cur_id_d  = win;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                unit_start_d = 1'b1;
                state_d      = WAIT;
`ifdef SCHED_TIMEOUT_EN
                cnt_d        = '0;
`endif
            end
            WAIT: begin
                if (bus.unit_done) begin
                    resp_data_d  = bus.unit_out;
                    resp_id_d    = cur_id_q;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (timeout) begin
                    resp_data_d  = '0;
                    resp_id_d    = cur_id_q;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (resp_valid_q && bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                    if (cur_id_q == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
                    else rr_ptr_d = cur_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cur_id_q     <= '0;
            gnt_q        <= '0;
            unit_start_q <= 1'b0;
            unit_in_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_id_q     <= cur_id_d;
            gnt_q        <= gnt_d;
            unit_start_q <= unit_start_d;
            unit_in_q    <= unit_in_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
`ifdef SCHED_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.unit_start = unit_start_q;
    assign bus.unit_in    = unit_in_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: doc/fsm_unit_scheduler.md
Name: fsm_unit_scheduler

Overview:
- Round-robin scheduler that shares one single-issue FSM compute unit (32-bit input in, 32-bit result out, start/done handshake) among NUM_REQ requesters.
- Sits between requester FSMs and the shared unit.
- Sequences each job: grant, issue, wait for done, return the result tagged with the requester id.
- One job is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, job operand and result width.
- ID_W, 3, requester-id width; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level; held until granted.
- req_data  input  NUM_REQ*DATA_W  packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
- unit_start  output  1  one-cycle start pulse to the unit.
- unit_in  output  DATA_W  operand to the unit; stable from ISSUE until the job completes.
- unit_done  input  1  one-cycle completion pulse from the unit.
- unit_out  input  DATA_W  unit result; valid while unit_done=1.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  ID_W  index of the requester that owns the response.
- resp_data  output  DATA_W  response result.
- resp_err  output  1  response aborted by timeout.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, rr_ptr=0;
  - gnt=0, unit_start=0, unit_in=0;
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
- Reset release takes effect on the first clk edge with reset=1.
- All outputs are registered.
- States (2-bit encoding): IDLE=0, ISSUE=1, WAIT=2, RESP=3.
- IDLE:
  - If req!=0, select the first asserted bit searching upward from rr_ptr with wrap (e.g. NUM_REQ=4, rr_ptr=2 gives search order 2,3,0,1).
  - Register gnt = one-hot(winner) for exactly one cycle.
  - Latch unit_in = the winner's req_data slice and cur_id = winner.
  - Transition to ISSUE.
- ISSUE:
  - unit_start=1 for this single cycle; gnt returns to 0.
  - Transition to WAIT.
- WAIT:
  - On unit_done=1, latch resp_data=unit_out and resp_id=cur_id, set resp_valid=1, resp_err=0, go to RESP.
  - unit_done is ignored in every other state.
- RESP:
  - Hold resp_* stable while resp_valid=1 and resp_ready=0.
  - When resp_valid & resp_ready: clear resp_valid, set rr_ptr = (cur_id+1) mod NUM_REQ, return to IDLE.
- Latency:
  - req rises in IDLE → gnt on the next edge → unit_start one cycle later.
  - unit_done → resp_valid one cycle later.
  - Best-case round trip with a 1-cycle unit and resp_ready tied high: 5 cycles from req to return to IDLE.
- Requests that arrive while busy wait; there are no queues. The requester keeps req high until it sees gnt and drops it the cycle after.
- req_data must be stable in the cycle before gnt; the controller samples it at the edge on which gnt is registered.
- rr_ptr only advances on response acceptance, so back-to-back requests from all requesters are served in strict rotation with no starvation.
- A reset asserted mid-job aborts the job with no response; the unit is assumed reset by the same signal.
- A winner index computed mod NUM_REQ never exceeds NUM_REQ-1.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit (or $clog2(TIMEOUT_CYCLES+1)-bit) counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without unit_done, go to RESP with resp_err=1, resp_data=0, resp_id=cur_id.
  - unit_done in the same cycle as the timeout wins, and resp_err=0.
- Not defined: no counter is built, resp_err is constant 0, and WAIT waits indefinitely.

Decomposition:
- Shared package fsm_sched_pkg holds:
  - the state encoding constants IDLE/ISSUE/WAIT/RESP (2-bit typedef sched_state_t);
  - the default widths.
- One natural sub-module, rr_pick: combinational round-robin priority picker. It takes req and rr_ptr and returns the winner index plus an any-valid flag.

Test Plan:
- Single request: req=4'b0010, req_data[1]=32'h1234, unit echoes after 3 cycles → gnt=4'b0010 for 1 cycle; unit_start 1 cycle later; resp_valid with resp_id=1, resp_data=32'h1234.
- Rotation: all four req held high, resp_ready=1 → grants in order 0,1,2,3,0; rr_ptr=1 after the first accept.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → resp_data/resp_id stable, no new gnt; accept on the 6th cycle → IDLE.
- Wrap search: rr_ptr=3, req=4'b0101 → winner 0, not 2.
- Async reset mid-WAIT: drop reset between edges → all outputs 0 immediately and state IDLE; after release, a fresh req=4'b1000 is granted at index 3.
- SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=10, unit never pulses done → resp_valid with resp_err=1, resp_data=0, 10 WAIT cycles after unit_start.
